alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU for the RISC-V core.
- Accepts one operation per valid/ready transfer and presents a registered result with zero/overflow flags.
- Holds the result under output back-pressure.
- Shifts run on an iterative 1-bit-per-cycle unit to save area; all other ops complete in one cycle.
- Sits between the decode/operand-fetch stage and writeback.

Parameters:
- WIDTH, 32, operand/result width; power of two, minimum 8.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  4  operation code (see package).
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B; shifts use src_b[SHAMT_W-1:0].
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow, ADD/SUB only; else 0.
- illegal  output  1  op was an unassigned code.
- busy  output  1  shift in progress.

Behaviour:
- Reset: synchronous, active-high; sampled only at a clk edge. While reset is high on an edge, all state is cleared:
  - state=IDLE, out_valid=0, result=0, zero=0, overflow=0, illegal=0, busy=0, shift counter=0.
  - Reset mid-shift or with a held result discards it silently; no out_valid follows.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. Accept when in_valid&in_ready.
    - Non-shift or illegal op: compute, register result/flags, go to DONE.
    - Shift op with shamt=0: result=src_a, go to DONE.
    - Shift op with shamt>0: load src_a and counter=shamt, go to SHIFT.
  - SHIFT: busy=1, in_ready=0. Each cycle shift 1 bit (SLL: zero fill; SRL: zero fill; SRA: sign fill) and decrement counter. When counter reaches 1, the final shift is applied and the FSM goes to DONE.
  - DONE: out_valid=1; result and flags stable until transfer.
    - On out_ready: if in_valid, accept the new op in the same cycle (in_ready = out_ready in DONE) and follow the IDLE rules; otherwise go to IDLE.
- Latency from accept edge:
  - Non-shift op: out_valid at the next edge (1 cycle).
  - Shift op: 1+shamt cycles.
  - Back-to-back non-shift ops sustain 1 op/cycle when out_ready=1.
- Arithmetic:
  - ADD/SUB are WIDTH-bit modulo; overflow is the signed overflow.
  - SLT is signed compare, SLTU unsigned compare; result is 1 or 0, zero-extended.
  - ANDN = a & ~b, ORN = a | ~b.
- Flags:
  - zero is computed from the final result for every op, including shifts.
  - Illegal op (0xC-0xF): result=0, zero=1, overflow=0, illegal=1; 1-cycle latency.
- Operand sampling: operands are sampled only on the accept edge; input changes afterwards have no effect.
- Output during DONE: out_valid never drops without out_ready, and result/flags do not change.

Decomposition:
- Shared package alu_pkg holds the op encoding as a 4-bit enum:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, ANDN=7, ORN=8, SLL=9, SRL=A, SRA=B; C-F unassigned.
  - The package also holds the FSM state typedef and an is_shift() helper.
- One sub-module, alu_shift_iter:
  - Holds the shift register, counter and direction/fill control.
  - Interface: start/done handshake to the FSM in alu_seq.
- Single-cycle ops are combinational logic inside alu_seq.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF, b=1, out_ready=1 -> 1 cycle later out_valid=1, result=0x80000000, overflow=1, zero=0. SUB a=5, b=5 -> result=0, zero=1, overflow=0.
- SRA a=0x80000000, b=4 -> busy for 4 cycles, in_ready=0 throughout, out_valid at accept+5, result=0xF8000000. SLL b=0 -> result=a at accept+1.
- Back-pressure: ADD 3+4 with out_ready=0 for 5 cycles -> result=7 held stable, out_valid=1, in_ready=0. Then out_ready=1 with a new AND 0xF0&0x3C pending -> both transfer in the same cycle; next result=0x30.
- Throughput: 8 consecutive XOR ops, in_valid=out_ready=1 -> one result per cycle, no bubbles, results in order.
- SLT a=0xFFFFFFFF, b=1 -> result=1. SLTU with the same operands -> result=0. op=0xD -> result=0, zero=1, illegal=1.
- Reset asserted at 3rd cycle of SRL with b=20 -> next edge out_valid=0, busy=0, in_ready=1, result=0. No stale result is ever presented.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: op encoding, FSM states and op-class helper.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpSub  = 4'h1,
    OpAnd  = 4'h2,
    OpOr   = 4'h3,
    OpXor  = 4'h4,
    OpSlt  = 4'h5,
    OpSltu = 4'h6,
    OpAndn = 4'h7,
    OpOrn  = 4'h8,
    OpSll  = 4'h9,
    OpSrl  = 4'hA,
    OpSra  = 4'hB
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OpSll) || (op == OpSrl) || (op == OpSra);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative 1-bit-per-cycle shifter; o_last flags the cycle whose shift is the final one.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [3:0]         i_op,
  input  logic [WIDTH-1:0]   i_value,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_last,
  output logic [WIDTH-1:0]   o_next
);

  logic [WIDTH-1:0]   r_val;
  logic [SHAMT_W-1:0] r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   w_next;

  always_comb begin
    w_next = {r_val[WIDTH-2:0], 1'b0};
    case (r_op)
      OpSrl:   w_next = {1'b0, r_val[WIDTH-1:1]};
      OpSra:   w_next = {r_val[WIDTH-1], r_val[WIDTH-1:1]};
      default: w_next = {r_val[WIDTH-2:0], 1'b0};
    endcase
  end

  assign o_next = w_next;
  assign o_last = (r_cnt == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_val <= '0;
      r_cnt <= '0;
      r_op  <= '0;
    end else if (i_start) begin
      r_val <= i_value;
      r_cnt <= i_shamt;
      r_op  <= i_op;
    end else if (r_cnt != '0) begin
      r_val <= w_next;
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops computed combinationally, shifts delegated to alu_shift_iter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             busy
);

  alu_state_e         r_state, w_state_d;
  logic [WIDTH-1:0]   r_result, w_res_d;
  logic               r_zero, r_ovf, r_ill;
  logic               w_ovf_d, w_ill_d, w_load, w_accept, w_start;
  logic [WIDTH-1:0]   w_sum, w_diff, w_alu_res;
  logic               w_alu_ovf, w_alu_ill;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_shift_last;
  logic [WIDTH-1:0]   w_shift_next;

  assign w_sum   = src_a + src_b;
  assign w_diff  = src_a - src_b;
  assign w_shamt = src_b[SHAMT_W-1:0];

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_ill = 1'b0;
    case (op)
      OpAdd: begin
        w_alu_res = w_sum;
        w_alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      OpSub: begin
        w_alu_res = w_diff;
        w_alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      OpAnd:  w_alu_res = src_a & src_b;
      OpOr:   w_alu_res = src_a | src_b;
      OpXor:  w_alu_res = src_a ^ src_b;
      OpSlt:  w_alu_res = WIDTH'($signed(src_a) < $signed(src_b));
      OpSltu: w_alu_res = WIDTH'(src_a < src_b);
      OpAndn: w_alu_res = src_a & ~src_b;
      OpOrn:  w_alu_res = src_a | ~src_b;
      // Only reached with a zero shift amount; non-zero amounts go to the iterative unit.
      OpSll, OpSrl, OpSra: w_alu_res = src_a;
      default: w_alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_res_d   = r_result;
    w_ovf_d   = r_ovf;
    w_ill_d   = r_ill;
    w_load    = 1'b0;
    w_accept  = 1'b0;
    w_start   = 1'b0;
    in_ready  = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        w_accept = in_valid;
      end
      StShift: begin
        if (w_shift_last) begin
          w_state_d = StDone;
          w_res_d   = w_shift_next;
          w_ovf_d   = 1'b0;
          w_ill_d   = 1'b0;
          w_load    = 1'b1;
        end
      end
      StDone: begin
        in_ready = out_ready;
        if (out_ready) begin
          w_state_d = StIdle;
          w_accept  = in_valid;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_accept) begin
      if (is_shift(op) && (w_shamt != '0)) begin
        w_start   = 1'b1;
        w_state_d = StShift;
      end else begin
        w_state_d = StDone;
        w_res_d   = w_alu_res;
        w_ovf_d   = w_alu_ovf;
        w_ill_d   = w_alu_ill;
        w_load    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_load) begin
        r_result <= w_res_d;
        r_zero   <= (w_res_d == '0);
        r_ovf    <= w_ovf_d;
        r_ill    <= w_ill_d;
      end
    end
  end

  alu_shift_iter #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_op    (op),
    .i_value (src_a),
    .i_shamt (w_shamt),
    .o_last  (w_shift_last),
    .o_next  (w_shift_next)
  );

  assign out_valid = (r_state == StDone);
  assign busy      = (r_state == StShift);
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign illegal   = r_ill;

endmodule
